// File: rtl/set_associative_icache_store_pkg.sv
// Shared definitions for the set-associative instruction-cache tag/data store.
//   - idx_width / way_width : address and way-select widths from SETS / WAYS
//   - flush_state_e         : flush FSM encoding (IDLE=0, FLUSH=1)
//   - plru_victim / plru_update : tree pseudo-LRU helpers, parametrised on ways
// PLRU trees use heap layout: node n has children 2n+1 (lower ways) and
// 2n+2 (upper ways), so for 4 ways the bits are b0 root, b1 ways 0/1, b2 ways 2/3.
package icache_pkg;

    localparam int PLRU_MAX_W   = 63;   // tree bits for up to 64 ways
    localparam int PLRU_IDX_W   = 6;
    localparam int PLRU_MAX_LVL = 6;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } flush_state_e;

    function automatic int idx_width(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Walk from the root: a 0 bit goes left (lower ways), a 1 bit goes right.
    function automatic int plru_victim(input logic [PLRU_MAX_W-1:0] bits, input int ways);
        int node;
        node = 0;
        for (int l = 0; l < PLRU_MAX_LVL; l++) begin
            if (l < $clog2(ways)) begin
                node = bits[PLRU_IDX_W'(node)] ? (2 * node + 2) : (2 * node + 1);
            end
        end
        return node - (ways - 1);
    endfunction

    // Point every node on the accessed way's path away from it. A left child
    // (odd node) sets its parent to 1, a right child (even node) sets it to 0.
    function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] bits,
                                                          input int way, input int ways);
        logic [PLRU_MAX_W-1:0] r;
        int node;
        int parent;
        r    = bits;
        node = way + ways - 1;
        for (int l = 0; l < PLRU_MAX_LVL; l++) begin
            if (l < $clog2(ways)) begin
                parent = (node - 1) / 2;
                r[PLRU_IDX_W'(parent)] = node[0];
                node = parent;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/set_associative_icache_store_if.sv
// Bus bundle between the cache store and its two clients.
//   master : fetch stage + refill controller (drive lookup, refill, flush)
//   slave  : the store (returns HIT/MISS/DATA_OUT, REFILL_READY, BUSY)
interface set_associative_icache_store_if
    import icache_pkg::*;
#(
    parameter int BLOCK_WIDTH = 512,
    parameter int SETS        = 64,
    parameter int TAG_WIDTH   = 26,
    localparam int IDX_W      = idx_width(SETS)
);
    logic                   LOOKUP_VALID;
    logic [IDX_W-1:0]       LOOKUP_INDEX;
    logic [TAG_WIDTH-1:0]   LOOKUP_TAG;
    logic                   HIT;
    logic                   MISS;
    logic [BLOCK_WIDTH-1:0] DATA_OUT;
    logic                   REFILL_VALID;
    logic [IDX_W-1:0]       REFILL_INDEX;
    logic [TAG_WIDTH-1:0]   REFILL_TAG;
    logic [BLOCK_WIDTH-1:0] REFILL_DATA;
    logic                   REFILL_READY;
    logic                   FLUSH;
    logic                   BUSY;

    modport master (
        output LOOKUP_VALID, LOOKUP_INDEX, LOOKUP_TAG,
        output REFILL_VALID, REFILL_INDEX, REFILL_TAG, REFILL_DATA, FLUSH,
        input  HIT, MISS, DATA_OUT, REFILL_READY, BUSY
    );

    modport slave (
        input  LOOKUP_VALID, LOOKUP_INDEX, LOOKUP_TAG,
        input  REFILL_VALID, REFILL_INDEX, REFILL_TAG, REFILL_DATA, FLUSH,
        output HIT, MISS, DATA_OUT, REFILL_READY, BUSY
    );
endinterface

// File: rtl/set_associative_icache_store_plru_tree.sv
// Combinational tree pseudo-LRU for one set.
//   bits       : current WAYS-1 tree bits of the set
//   access_way : way being touched this cycle
//   victim     : way the tree currently points at
//   next_bits  : tree bits after marking access_way most-recently-used
module plru_tree
    import icache_pkg::*;
#(
    parameter int WAYS   = 4,
    localparam int WAY_W = way_width(WAYS)
) (
    input  logic [WAYS-2:0]  bits,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim,
    output logic [WAYS-2:0]  next_bits
);
    assign victim    = WAY_W'(plru_victim(PLRU_MAX_W'(bits), WAYS));
    assign next_bits = (WAYS-1)'(plru_update(PLRU_MAX_W'(bits), int'(access_way), WAYS));
endmodule

// File: rtl/set_associative_icache_store.sv
// N-way set-associative tag/data store for the instruction cache.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave side of set_associative_icache_store_if
//                lookup  -> registered HIT/MISS/DATA_OUT one cycle later
//                refill  -> write with automatic way choice, REFILL_READY = !BUSY
//                FLUSH   -> one valid/PLRU set cleared per cycle, BUSY for SETS cycles
module set_associative_icache_store
    import icache_pkg::*;
#(
    parameter int BLOCK_WIDTH = 512,
    parameter int SETS        = 64,
    parameter int WAYS        = 4,
    parameter int TAG_WIDTH   = 26
) (
    input logic                          CLK,
    input logic                          RST_N,
    set_associative_icache_store_if.slave bus
);
    localparam int IDX_W = idx_width(SETS);
    localparam int WAY_W = way_width(WAYS);

    logic [WAYS-1:0]        valid_q  [SETS];
    logic [WAYS-2:0]        plru_q   [SETS];
    logic [TAG_WIDTH-1:0]   tag_mem  [SETS][WAYS];
    logic [BLOCK_WIDTH-1:0] data_mem [SETS][WAYS];

    flush_state_e           state_q, state_d;
    logic [IDX_W-1:0]       cnt_q;
    logic                   busy;

    logic                   hit_p1, miss_p1;
    logic [BLOCK_WIDTH-1:0] data_p1;

    logic                   lk_acc, rf_acc, lk_hit, rf_has_inv;
    logic [WAYS-1:0]        lk_match, rf_match;
    logic [WAY_W-1:0]       lk_way, rf_hit_way, rf_inv_way, rf_victim, rf_way;
    logic [WAY_W-1:0]       lk_victim_unused;
    logic [WAYS-2:0]        lk_plru_next, rf_plru_base, rf_plru_next;

    assign busy             = (state_q == S_FLUSH);
    assign lk_acc           = bus.LOOKUP_VALID && !busy;
    assign rf_acc           = bus.REFILL_VALID && !busy;
    assign bus.REFILL_READY = !busy;
    assign bus.BUSY         = busy;
    assign bus.HIT          = hit_p1;
    assign bus.MISS         = miss_p1;
    assign bus.DATA_OUT     = data_p1;

    always_comb begin
        lk_match   = '0;
        rf_match   = '0;
        lk_way     = '0;
        rf_hit_way = '0;
        rf_inv_way = '0;
        rf_has_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            lk_match[w] = valid_q[bus.LOOKUP_INDEX][w] &&
                          (tag_mem[bus.LOOKUP_INDEX][w] == bus.LOOKUP_TAG);
            rf_match[w] = valid_q[bus.REFILL_INDEX][w] &&
                          (tag_mem[bus.REFILL_INDEX][w] == bus.REFILL_TAG);
        end
        // Descending scan so the lowest-numbered way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) lk_way = WAY_W'(w);
            if (rf_match[w]) rf_hit_way = WAY_W'(w);
            if (!valid_q[bus.REFILL_INDEX][w]) begin
                rf_has_inv = 1'b1;
                rf_inv_way = WAY_W'(w);
            end
        end
        lk_hit = |lk_match;
    end

    // Same-set lookup hit and refill: the refill update is layered on top
    // of the lookup's update so the refill is the last access recorded.
    assign rf_plru_base = (lk_acc && lk_hit && (bus.LOOKUP_INDEX == bus.REFILL_INDEX))
                          ? lk_plru_next : plru_q[bus.REFILL_INDEX];
    assign rf_way = (|rf_match) ? rf_hit_way : (rf_has_inv ? rf_inv_way : rf_victim);

    plru_tree #(.WAYS(WAYS)) u_plru_lookup (
        .bits       (plru_q[bus.LOOKUP_INDEX]),
        .access_way (lk_way),
        .victim     (lk_victim_unused),
        .next_bits  (lk_plru_next)
    );

    plru_tree #(.WAYS(WAYS)) u_plru_refill (
        .bits       (rf_plru_base),
        .access_way (rf_way),
        .victim     (rf_victim),
        .next_bits  (rf_plru_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.FLUSH) state_d = S_FLUSH;
            S_FLUSH: if (cnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: lookup result registers, valid/PLRU state, flush sweep.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            hit_p1  <= 1'b0;
            miss_p1 <= 1'b0;
            data_p1 <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_p1  <= lk_acc && lk_hit;
            miss_p1 <= lk_acc && !lk_hit;
            data_p1 <= (lk_acc && lk_hit) ? data_mem[bus.LOOKUP_INDEX][lk_way] : '0;
            if (lk_acc && lk_hit) begin
                plru_q[bus.LOOKUP_INDEX] <= lk_plru_next;
            end
            if (rf_acc) begin
                valid_q[bus.REFILL_INDEX][rf_way] <= 1'b1;
                plru_q[bus.REFILL_INDEX]          <= rf_plru_next;
            end
            if (state_q == S_FLUSH) begin
                valid_q[cnt_q] <= '0;
                plru_q[cnt_q]  <= '0;
                cnt_q          <= cnt_q + 1'b1;
            end else if (bus.FLUSH) begin
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rf_acc) begin
            tag_mem[bus.REFILL_INDEX][rf_way]  <= bus.REFILL_TAG;
            data_mem[bus.REFILL_INDEX][rf_way] <= bus.REFILL_DATA;
        end
    end

endmodule

// File: tb/tb_set_associative_icache_store.sv
// Directed bench for set_associative_icache_store with a response scoreboard.
module tb_set_associative_icache_store;
    localparam int BW   = 512;
    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int TW   = 26;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    set_associative_icache_store_if #(.BLOCK_WIDTH(BW), .SETS(SETS), .TAG_WIDTH(TW)) bus ();

    set_associative_icache_store #(
        .BLOCK_WIDTH(BW), .SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic        hit;
        logic [BW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;
    int lk_id = 0;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: pops one expectation per presented response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.HIT || bus.MISS) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", {bus.HIT, bus.MISS}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("lookup%0d_hit", mon_e.id), bus.HIT, mon_e.hit);
                    chk($sformatf("lookup%0d_miss", mon_e.id), bus.MISS, !mon_e.hit);
                    chk($sformatf("lookup%0d_data", mon_e.id), bus.DATA_OUT, mon_e.data);
                end
            end else begin
                chk("idle_data_zero", bus.DATA_OUT, 0);
            end
        end
    end

    task automatic lookup(input logic [5:0] idx, input logic [TW-1:0] tag,
                          input logic exp_hit, input logic [BW-1:0] exp_data);
        bus.LOOKUP_VALID = 1'b1;
        bus.LOOKUP_INDEX = idx;
        bus.LOOKUP_TAG   = tag;
        exp_q.push_back('{id: lk_id, hit: exp_hit, data: exp_data});
        lk_id++;
        @(posedge clk); #1;
        bus.LOOKUP_VALID = 1'b0;
    endtask

    task automatic refill(input logic [5:0] idx, input logic [TW-1:0] tag, input logic [BW-1:0] data);
        bus.REFILL_VALID = 1'b1;
        bus.REFILL_INDEX = idx;
        bus.REFILL_TAG   = tag;
        bus.REFILL_DATA  = data;
        @(posedge clk); #1;
        bus.REFILL_VALID = 1'b0;
    endtask

    task automatic fill4(input logic [5:0] idx, input logic [BW-1:0] base);
        refill(idx, 26'hA, base + 1);
        refill(idx, 26'hB, base + 2);
        refill(idx, 26'hC, base + 3);
        refill(idx, 26'hD, base + 4);
    endtask

    int busy_cycles;
    int ready_bad;
    bit done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.LOOKUP_VALID = 1'b0; bus.LOOKUP_INDEX = '0; bus.LOOKUP_TAG = '0;
        bus.REFILL_VALID = 1'b0; bus.REFILL_INDEX = '0; bus.REFILL_TAG = '0;
        bus.REFILL_DATA  = '0;   bus.FLUSH = 1'b0;

        #12;
        chk("reset_hit", bus.HIT, 0);
        chk("reset_miss", bus.MISS, 0);
        chk("reset_data", bus.DATA_OUT, 0);
        chk("reset_busy", bus.BUSY, 0);
        chk("reset_ready", bus.REFILL_READY, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty cache misses.
        lookup(5, 26'hA, 1'b0, 0);

        // Ways 0..3 filled in order; hit on C.
        fill4(5, 0);
        lookup(5, 26'hC, 1'b1, 3);

        // Set 6: full, no hits -> E replaces way 0 (A).
        fill4(6, 512'h10);
        refill(6, 26'hE, 512'h15);
        lookup(6, 26'hA, 1'b0, 0);
        lookup(6, 26'hE, 1'b1, 512'h15);
        lookup(6, 26'hB, 1'b1, 512'h12);

        // Set 7: hit way 1 -> tree b0=1,b1=0,b2=0 -> victim way 2 (C).
        fill4(7, 512'h20);
        lookup(7, 26'hB, 1'b1, 512'h22);
        refill(7, 26'hE, 512'h25);
        lookup(7, 26'hC, 1'b0, 0);
        lookup(7, 26'hB, 1'b1, 512'h22);
        lookup(7, 26'hE, 1'b1, 512'h25);

        // Refill an existing tag overwrites in place.
        refill(7, 26'hB, 512'h9);
        lookup(7, 26'hB, 1'b1, 512'h9);
        lookup(7, 26'hA, 1'b1, 512'h21);
        lookup(7, 26'hD, 1'b1, 512'h24);
        lookup(7, 26'hE, 1'b1, 512'h25);

        // Same-cycle lookup and refill of the same tag: read-before-write.
        bus.REFILL_VALID = 1'b1; bus.REFILL_INDEX = 8; bus.REFILL_TAG = 26'hF;
        bus.REFILL_DATA  = 512'h31;
        bus.LOOKUP_VALID = 1'b1; bus.LOOKUP_INDEX = 8; bus.LOOKUP_TAG = 26'hF;
        exp_q.push_back('{id: lk_id, hit: 1'b0, data: 0});
        lk_id++;
        @(posedge clk); #1;
        bus.REFILL_VALID = 1'b0; bus.LOOKUP_VALID = 1'b0;
        lookup(8, 26'hF, 1'b1, 512'h31);

        // Flush, with a refill to set 10 accepted in the raising cycle.
        bus.FLUSH = 1'b1;
        bus.REFILL_VALID = 1'b1; bus.REFILL_INDEX = 10; bus.REFILL_TAG = 26'h11;
        bus.REFILL_DATA  = 512'h41;
        chk("ready_at_flush_raise", bus.REFILL_READY, 1);
        @(posedge clk); #1;
        bus.FLUSH = 1'b0; bus.REFILL_VALID = 1'b0;
        busy_cycles = 0; ready_bad = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.BUSY) begin
                busy_cycles++;
                if (bus.REFILL_READY) ready_bad++;
            end else begin
                done = 1'b1;
            end
            if (i == 3) begin
                bus.LOOKUP_VALID = 1'b1; bus.LOOKUP_INDEX = 5; bus.LOOKUP_TAG = 26'hC;
            end
            if (i == 4) bus.LOOKUP_VALID = 1'b0;
            if (i == 5) bus.FLUSH = 1'b1;
            if (i == 6) bus.FLUSH = 1'b0;
            if (i == 7) begin
                bus.REFILL_VALID = 1'b1; bus.REFILL_INDEX = 9; bus.REFILL_TAG = 26'h10;
                bus.REFILL_DATA  = 512'h51;
            end
            if (i == 8) bus.REFILL_VALID = 1'b0;
        end
        chk("flush_busy_cycles", busy_cycles, 64);
        chk("flush_ready_low", ready_bad, 0);
        @(posedge clk); #1;

        lookup(5, 26'hC, 1'b0, 0);
        lookup(6, 26'hE, 1'b0, 0);
        lookup(7, 26'hB, 1'b0, 0);
        lookup(8, 26'hF, 1'b0, 0);
        lookup(9, 26'h10, 1'b0, 0);
        lookup(10, 26'h11, 1'b0, 0);

        refill(5, 26'hA, 512'h77);
        lookup(5, 26'hA, 1'b1, 512'h77);

        // Reset in the middle of a second flush.
        bus.FLUSH = 1'b1;
        @(posedge clk); #1;
        bus.FLUSH = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_reset", bus.BUSY, 1);
        rst_n = 1'b0;
        #1;
        chk("busy_after_reset", bus.BUSY, 0);
        chk("ready_after_reset", bus.REFILL_READY, 1);
        chk("hit_after_reset", bus.HIT, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lookup(5, 26'hA, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_responses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/set_associative_icache_store.md
Name: set_associative_icache_store

Overview:
- Parametrised N-way set-associative tag/data store for the RISC-V instruction cache.
- Replaces the single fully-associative store.
- Adds per-way valid bits, tree pseudo-LRU replacement, a registered hit/miss lookup, a refill write port with automatic victim selection, and a multi-cycle flash-invalidate (flush).
- Sits between the fetch stage (lookup) and the refill controller (refill, flush).

Parameters:
- BLOCK_WIDTH, 512: cache line width in bits.
- SETS, 64: number of sets; power of 2, ≥2. IDX_W = $clog2(SETS).
- WAYS, 4: associativity; power of 2, ≥2. PLRU tree holds WAYS-1 bits per set.
- TAG_WIDTH, 26: tag width in bits.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- RST_N, input, 1: reset, asynchronous, active-low.
- LOOKUP_VALID, input, 1: lookup request.
- LOOKUP_INDEX, input, IDX_W: set index of the lookup.
- LOOKUP_TAG, input, TAG_WIDTH: tag to compare.
- HIT, output, 1: registered; lookup from the previous cycle hit.
- MISS, output, 1: registered; lookup from the previous cycle missed.
- DATA_OUT, output, BLOCK_WIDTH: registered; line of the hitting way, all zeros otherwise.
- REFILL_VALID, input, 1: refill write request.
- REFILL_INDEX, input, IDX_W: set index to write.
- REFILL_TAG, input, TAG_WIDTH: tag to write.
- REFILL_DATA, input, BLOCK_WIDTH: line to write.
- REFILL_READY, output, 1: refill accepted this cycle; equals !BUSY (combinational).
- FLUSH, input, 1: one-cycle pulse requesting invalidate-all.
- BUSY, output, 1: registered; high while the flush is in progress.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All valid bits and PLRU bits cleared.
  - HIT=0, MISS=0, DATA_OUT=0, BUSY=0.
  - FSM forced to IDLE, flush counter cleared.
  - Tag and data arrays are not reset.
  - Reset asserted mid-flush aborts the flush; all valid bits end up cleared anyway.
- Lookup:
  - Accepted when LOOKUP_VALID=1 and BUSY=0.
  - Compare LOOKUP_TAG against every way with its valid bit set.
  - One-cycle latency: on the next edge, HIT=1/MISS=0 with DATA_OUT = data of the hitting way.
  - No lookup accepted that cycle → HIT=0, MISS=0, DATA_OUT=0 on the next edge.
  - HIT and MISS are never both 1.
  - A hit updates the set's PLRU to mark the hit way most-recently-used.
- Refill (accepted when REFILL_VALID=1 and REFILL_READY=1):
  - If REFILL_TAG already matches a valid way in the set, overwrite that way; no duplicates.
  - Otherwise, if any way is invalid, write the lowest-numbered invalid way.
  - Otherwise, write the PLRU victim.
  - The written way gets tag, data and valid=1, and is marked MRU.
- PLRU tree:
  - Traversal: node bit 0 → go left (lower ways), bit 1 → go right.
  - Access to way w sets each node on w's path to point away from w.
  - WAYS=4: bits b0 (root), b1 (ways 0/1), b2 (ways 2/3).
- Same-cycle lookup and refill:
  - Lookup reads pre-edge contents (read-before-write), so a lookup of the tag being refilled reports MISS.
  - If both touch the same set, refill's PLRU update is applied last.
- Flush FSM:
  - States IDLE, FLUSH.
  - IDLE: FLUSH=1 → go to FLUSH with counter=0; BUSY=1 from the next cycle.
  - FLUSH: each cycle clear valid and PLRU bits of set[counter], then increment counter.
  - FLUSH: when counter==SETS-1, return to IDLE; BUSY=0 on the following cycle. Total BUSY time is exactly SETS cycles.
  - A FLUSH pulse during FLUSH is ignored.
  - A refill accepted in the same cycle FLUSH is raised is still written, and is later cleared by the flush.
- Width rules:
  - Counter is IDX_W bits and wraps naturally.
  - Way select is $clog2(WAYS) bits; no arithmetic overflow paths.

Decomposition:
- Package icache_pkg:
  - Index and way width functions.
  - FSM state encoding (IDLE=0, FLUSH=1).
  - PLRU victim and update functions parametrised on WAYS.
- Sub-module plru_tree:
  - Combinational victim select.
  - Next-state update from the accessed way for one set's bit-vector.
  - Instanced once for lookup, once for refill.

Test Plan:
- Reset, then lookup index 5 tag 0xA → one cycle later HIT=0, MISS=1, DATA_OUT=0.
- Refill set 5 with tags A, B, C, D (data 1, 2, 3, 4) → ways 0..3 filled in order; lookup C → HIT=1, DATA_OUT=3.
- With set 5 full and no further hits, refill tag E → replaces way 0; lookup A → MISS, lookup E → HIT.
- Same fill as above, then hit on B (way 1), then refill E → replaces way 2 (C); lookup C → MISS, lookup B → HIT.
- Refill tag B again with data 9 → way 1 overwritten, no duplicate; lookup B → DATA_OUT=9.
- Pulse FLUSH with SETS=64 → BUSY high for exactly 64 cycles and REFILL_READY=0 throughout; lookups during flush → HIT=0, MISS=0; after flush every prior tag MISSes; RST_N low at cycle 10 of the flush → BUSY=0 immediately.
